// File: rtl/key_repeat_ctrl_pkg.sv
// Shared definitions for the key-handling blocks: FSM encoding and default timing.
package key_repeat_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DELAY  = 2'd1,
    ST_REPEAT = 2'd2
  } key_state_e;

  localparam int DEF_DELAY_TICKS = 8;
  localparam int DEF_RATE_TICKS  = 3;
  localparam int DEF_CNT_W       = 4;
  localparam int DEF_REP_W       = 8;

endpackage

// File: rtl/key_tick_timer.sv
// CE-qualified down-counter with load, decrement and a zero flag.
module key_tick_timer #(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             ce,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  output logic [CNT_W-1:0] cnt,
  output logic             zero
);

  always_ff @(posedge clk) begin
    if (clr) begin
      cnt <= '0;
    end else if (ce) begin
      if (load) begin
        cnt <= load_val;
      end else if (dec && (cnt != '0)) begin
        cnt <= cnt - CNT_W'(1);
      end
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/key_repeat_ctrl.sv
// Turns a debounced key level into press/repeat/release pulses, a toggle level and a repeat count.
//   state     | meaning
//   ST_IDLE   | key released, waiting for a press
//   ST_DELAY  | pressed, counting the initial hold delay
//   ST_REPEAT | held past the delay, issuing repeats every RATE_TICKS
module key_repeat_ctrl
  import key_repeat_ctrl_pkg::*;
#(
  parameter int DELAY_TICKS = DEF_DELAY_TICKS,
  parameter int RATE_TICKS  = DEF_RATE_TICKS,
  parameter int CNT_W       = DEF_CNT_W,
  parameter int REP_W       = DEF_REP_W
) (
  input  logic             CLK,
  input  logic             CLR,
  input  logic             CE,
  input  logic             KEY_LEVEL,
  output logic             KEY_PRESS,
  output logic             KEY_REL,
  output logic             KEY_TOG,
  output logic             KEY_HELD,
  output logic [REP_W-1:0] REP_CNT
);

  localparam logic [CNT_W-1:0] DELAY_LOAD = CNT_W'(DELAY_TICKS - 1);
  localparam logic [CNT_W-1:0] RATE_LOAD  = CNT_W'(RATE_TICKS - 1);

  key_state_e       state_q, state_d;
  logic             tmr_load, tmr_dec, tmr_zero;
  logic [CNT_W-1:0] tmr_load_val, tmr_cnt;
  logic             press_d, rel_d, tog_d;
  logic [REP_W-1:0] rep_d, rep_inc;

  key_tick_timer #(.CNT_W(CNT_W)) u_timer (
    .clk      (CLK),
    .clr      (CLR),
    .ce       (CE),
    .load     (tmr_load),
    .load_val (tmr_load_val),
    .dec      (tmr_dec),
    .cnt      (tmr_cnt),
    .zero     (tmr_zero)
  );

  // Saturating increment: the count sticks at all-ones instead of wrapping.
  assign rep_inc = (REP_CNT == {REP_W{1'b1}}) ? REP_CNT : REP_CNT + REP_W'(1);

  always_comb begin
    state_d      = state_q;
    tmr_load     = 1'b0;
    tmr_load_val = '0;
    tmr_dec      = 1'b0;
    press_d      = 1'b0;
    rel_d        = 1'b0;
    tog_d        = KEY_TOG;
    rep_d        = REP_CNT;
    if (CE) begin
      case (state_q)
        ST_IDLE: begin
          if (KEY_LEVEL) begin
            state_d      = ST_DELAY;
            tmr_load     = 1'b1;
            tmr_load_val = DELAY_LOAD;
            press_d      = 1'b1;
            tog_d        = ~KEY_TOG;
            rep_d        = '0;
          end
        end
        ST_DELAY, ST_REPEAT: begin
          // Release wins over a repeat falling due on the same tick.
          if (!KEY_LEVEL) begin
            state_d = ST_IDLE;
            rel_d   = 1'b1;
          end else if (tmr_zero) begin
            state_d      = ST_REPEAT;
            tmr_load     = 1'b1;
            tmr_load_val = RATE_LOAD;
            press_d      = 1'b1;
            rep_d        = rep_inc;
          end else begin
            tmr_dec = 1'b1;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (CLR) begin
      state_q   <= ST_IDLE;
      KEY_PRESS <= 1'b0;
      KEY_REL   <= 1'b0;
      KEY_TOG   <= 1'b0;
      KEY_HELD  <= 1'b0;
      REP_CNT   <= '0;
    end else begin
      state_q   <= state_d;
      KEY_PRESS <= press_d;
      KEY_REL   <= rel_d;
      KEY_TOG   <= tog_d;
      KEY_HELD  <= (state_d != ST_IDLE);
      REP_CNT   <= rep_d;
    end
  end

endmodule

// File: tb/tb_key_repeat_ctrl.sv
// Bench for key_repeat_ctrl: default instance plus a DELAY=1/RATE=1/REP_W=2 instance on shared stimulus.
module tb_key_repeat_ctrl;

  logic CLK = 1'b0;
  logic CLR, CE, KEY_LEVEL;

  logic       press_a, rel_a, tog_a, held_a;
  logic [7:0] rep_a;
  logic       press_b, rel_b, tog_b, held_b;
  logic [1:0] rep_b;

  int checks = 0;
  int errors = 0;
  int press_total_a = 0;

  always #5 CLK = ~CLK;

  key_repeat_ctrl #(.DELAY_TICKS(8), .RATE_TICKS(3), .CNT_W(4), .REP_W(8)) dut_a (
    .CLK(CLK), .CLR(CLR), .CE(CE), .KEY_LEVEL(KEY_LEVEL),
    .KEY_PRESS(press_a), .KEY_REL(rel_a), .KEY_TOG(tog_a), .KEY_HELD(held_a), .REP_CNT(rep_a)
  );

  key_repeat_ctrl #(.DELAY_TICKS(1), .RATE_TICKS(1), .CNT_W(4), .REP_W(2)) dut_b (
    .CLK(CLK), .CLR(CLR), .CE(CE), .KEY_LEVEL(KEY_LEVEL),
    .KEY_PRESS(press_b), .KEY_REL(rel_b), .KEY_TOG(tog_b), .KEY_HELD(held_b), .REP_CNT(rep_b)
  );

  // Model: a repeat is due when the ticks since the press n satisfy n>=D and (n-D)%R==0.
  int m_d[2]   = '{8, 1};
  int m_r[2]   = '{3, 1};
  int m_max[2] = '{255, 3};
  int m_n[2]   = '{0, 0};
  int m_rep[2] = '{0, 0};
  bit m_held[2]  = '{0, 0};
  bit m_press[2] = '{0, 0};
  bit m_rel[2]   = '{0, 0};
  bit m_tog[2]   = '{0, 0};

  always @(posedge CLK) begin
    for (int i = 0; i < 2; i++) begin
      automatic int nn = m_n[i];
      automatic int nrep = m_rep[i];
      automatic bit nh = m_held[i];
      automatic bit np = 1'b0;
      automatic bit nr = 1'b0;
      automatic bit nt = m_tog[i];
      if (CLR) begin
        nn = 0; nrep = 0; nh = 0; nt = 0;
      end else if (CE) begin
        if (!m_held[i] && KEY_LEVEL) begin
          nh = 1; nn = 0; np = 1; nt = ~m_tog[i]; nrep = 0;
        end else if (m_held[i] && !KEY_LEVEL) begin
          nh = 0; nr = 1;
        end else if (m_held[i]) begin
          nn = m_n[i] + 1;
          if (nn >= m_d[i] && ((nn - m_d[i]) % m_r[i]) == 0) begin
            np = 1;
            if (nrep < m_max[i]) nrep = nrep + 1;
          end
        end
      end
      m_n[i]     <= nn;
      m_rep[i]   <= nrep;
      m_held[i]  <= nh;
      m_press[i] <= np;
      m_rel[i]   <= nr;
      m_tog[i]   <= nt;
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge CLK) begin
    chk("a_press", int'(press_a), int'(m_press[0]));
    chk("a_rel",   int'(rel_a),   int'(m_rel[0]));
    chk("a_tog",   int'(tog_a),   int'(m_tog[0]));
    chk("a_held",  int'(held_a),  int'(m_held[0]));
    chk("a_rep",   int'(rep_a),   m_rep[0]);
    chk("b_press", int'(press_b), int'(m_press[1]));
    chk("b_rel",   int'(rel_b),   int'(m_rel[1]));
    chk("b_tog",   int'(tog_b),   int'(m_tog[1]));
    chk("b_held",  int'(held_b),  int'(m_held[1]));
    chk("b_rep",   int'(rep_b),   m_rep[1]);
    if (press_a && rel_a) chk("a_press_and_rel", 1, 0);
    if (press_a) press_total_a++;
  end

  // One CE tick every 4 CLK; called and returns on a falling edge.
  task automatic tick(input logic lvl);
    KEY_LEVEL = lvl;
    CE = 1'b1;
    @(negedge CLK);
    CE = 1'b0;
    repeat (3) @(negedge CLK);
  endtask

  task automatic ticks(input int n, input logic lvl);
    for (int k = 0; k < n; k++) tick(lvl);
  endtask

  int snap;

  initial begin
    CLR = 1'b1; CE = 1'b0; KEY_LEVEL = 1'b0;
    repeat (3) @(negedge CLK);
    CLR = 1'b0;

    // Quiet input
    ticks(20, 1'b0);
    chk("quiet_held", int'(held_a), 0);
    chk("quiet_tog", int'(tog_a), 0);

    // Short tap
    snap = press_total_a;
    ticks(3, 1'b1);
    chk("tap_held", int'(held_a), 1);
    tick(1'b0);
    chk("tap_press_cnt", press_total_a - snap, 1);
    chk("tap_tog", int'(tog_a), 1);
    chk("tap_rep", int'(rep_a), 0);
    chk("tap_held_after", int'(held_a), 0);

    // Long hold: presses at ticks 0,8,11,14,17
    snap = press_total_a;
    ticks(20, 1'b1);
    chk("long_press_cnt", press_total_a - snap, 5);
    chk("long_rep", int'(rep_a), 4);
    chk("long_tog", int'(tog_a), 0);
    chk("sat_rep_b", int'(rep_b), 3);
    tick(1'b0);
    chk("long_rep_after_rel", int'(rep_a), 4);
    ticks(2, 1'b0);

    // Release collides with the first repeat
    snap = press_total_a;
    ticks(8, 1'b1);
    tick(1'b0);
    chk("coll_press_cnt", press_total_a - snap, 1);
    chk("coll_rep", int'(rep_a), 0);
    chk("coll_held", int'(held_a), 0);
    ticks(2, 1'b0);

    // CE gating mid-DELAY
    snap = press_total_a;
    ticks(4, 1'b1);
    for (int k = 0; k < 50; k++) begin
      KEY_LEVEL = ~KEY_LEVEL;
      @(negedge CLK);
    end
    chk("gate_press_cnt", press_total_a - snap, 1);
    chk("gate_held", int'(held_a), 1);
    ticks(10, 1'b1);
    chk("gate_resume_cnt", press_total_a - snap, 3);
    chk("gate_rep", int'(rep_a), 2);
    tick(1'b0);
    ticks(2, 1'b0);

    // Reset in the middle of REPEAT, key still held
    ticks(10, 1'b1);
    chk("pre_rst_held", int'(held_a), 1);
    KEY_LEVEL = 1'b1;
    CLR = 1'b1;
    @(negedge CLK);
    chk("rst_held", int'(held_a), 0);
    chk("rst_rel", int'(rel_a), 0);
    chk("rst_rep", int'(rep_a), 0);
    chk("rst_tog", int'(tog_a), 0);
    CLR = 1'b0;
    @(negedge CLK);
    snap = press_total_a;
    tick(1'b1);
    chk("post_rst_press", press_total_a - snap, 1);
    chk("post_rst_tog", int'(tog_a), 1);
    ticks(3, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/key_repeat_ctrl.md
Name: key_repeat_ctrl

Overview:
- Converts a debounced key level into key events:
  - a press pulse;
  - typematic repeat pulses after an initial hold delay;
  - a release pulse;
  - a toggle (on/off) level.
- Sits downstream of the switch debouncer in the same sampling domain.
- Uses the same CE sample tick, so all delays are counted in debounce ticks.
- Feeds counters, menus and display logic.

Parameters:
- DELAY_TICKS, 8, ticks from the press pulse to the first repeat pulse; legal range 1 to 2**CNT_W-1.
- RATE_TICKS, 3, ticks between consecutive repeat pulses; legal range 1 to 2**CNT_W-1.
- CNT_W, 4, width of the internal tick timer.
- REP_W, 8, width of the REP_CNT output.

Ports:
- CLK  in  1  system clock; all logic on the rising edge.
- CLR  in  1  synchronous, active-high reset.
- CE  in  1  sample tick. One CLK wide; FSM and timer advance only when CE=1.
- KEY_LEVEL  in  1  debounced key level; 1 = pressed.
- KEY_PRESS  out  1  one-CLK pulse on the initial press and on every repeat.
- KEY_REL  out  1  one-CLK pulse on release.
- KEY_TOG  out  1  toggle level; inverts on each initial press only, never on repeats.
- KEY_HELD  out  1  1 while the FSM is not IDLE.
- REP_CNT  out  REP_W  repeats issued in the current or last hold; saturating.

Behaviour:
- Interface (already decided): single clock CLK. CLR is synchronous and active-high.
- All outputs are registered.
- Reset: CLR=1 at a CLK edge forces:
  - state=IDLE, timer=0;
  - KEY_PRESS=0, KEY_REL=0, KEY_TOG=0, KEY_HELD=0, REP_CNT=0.
  - CLR overrides CE and overrides any operation in progress. No release pulse is emitted on reset.
- CE=0 cycles:
  - state, timer, KEY_TOG and REP_CNT hold their values;
  - KEY_PRESS=0 and KEY_REL=0.
- Event latency: an event decided at a CE=1 edge appears on its output for exactly that one following CLK cycle.
- FSM transitions, evaluated only at CE=1 edges:
  - IDLE, KEY_LEVEL=1: go to DELAY; timer<=DELAY_TICKS-1; KEY_PRESS pulse; KEY_TOG inverts; REP_CNT<=0.
  - IDLE, KEY_LEVEL=0: stay in IDLE.
  - DELAY, KEY_LEVEL=0: go to IDLE; KEY_REL pulse.
  - DELAY, KEY_LEVEL=1, timer==0: go to REPEAT; timer<=RATE_TICKS-1; KEY_PRESS pulse; REP_CNT+1.
  - DELAY, KEY_LEVEL=1, timer!=0: timer-1.
  - REPEAT, KEY_LEVEL=0: go to IDLE; KEY_REL pulse.
  - REPEAT, KEY_LEVEL=1, timer==0: timer<=RATE_TICKS-1; KEY_PRESS pulse; REP_CNT+1.
  - REPEAT, KEY_LEVEL=1, timer!=0: timer-1.
- Resulting timing: with the press at tick t0, repeats occur at t0+DELAY_TICKS, then every RATE_TICKS ticks after that.
- Release has priority over repeat: if KEY_LEVEL=0 on the tick where timer==0, only KEY_REL pulses.
- KEY_PRESS and KEY_REL are never both 1 in the same cycle.
- Detection is level-based: if KEY_LEVEL is already 1 when CLR deasserts, the first CE tick produces a press.
- KEY_LEVEL changes between CE ticks are ignored; only the value at CE edges matters.
- REP_CNT:
  - saturates at 2**REP_W-1 and does not wrap;
  - retains its value after release until the next initial press clears it.
- KEY_HELD = (state != IDLE), registered alongside the state.
- Boundary case DELAY_TICKS=1: the first repeat comes on the tick right after the press. RATE_TICKS=1 gives a repeat on every tick.

Decomposition:
- Shared package/include:
  - FSM state encoding: IDLE=2'd0, DELAY=2'd1, REPEAT=2'd2 (2'd3 is illegal and recovers to IDLE);
  - default DELAY_TICKS, RATE_TICKS and CNT_W values, shared with the other key-handling blocks.
- Natural sub-module: key_tick_timer, a CNT_W-bit load/decrement/zero-flag down-counter qualified by CE.
- The FSM and output registers stay in key_repeat_ctrl.

Test Plan:
- Reset and quiet input:
  - Stimulus: CLR=1 for 3 CLK, then KEY_LEVEL=0 with CE every 4 CLK for 20 ticks.
  - Required response: all outputs 0 throughout.
- Short tap:
  - Stimulus: KEY_LEVEL=1 for 3 ticks, then 0.
  - Required response: one KEY_PRESS pulse, then one KEY_REL pulse 3 ticks later. KEY_TOG 0->1, REP_CNT=0, KEY_HELD high for 3 ticks.
- Long hold (defaults):
  - Stimulus: KEY_LEVEL=1 for 20 ticks.
  - Required response: KEY_PRESS at ticks 0, 8, 11, 14, 17, each exactly 1 CLK wide. REP_CNT ends at 4, KEY_TOG toggles once. Release at tick 20 gives KEY_REL, and REP_CNT stays 4.
- Release collides with repeat:
  - Stimulus: KEY_LEVEL drops at tick 8.
  - Required response: KEY_REL only, no KEY_PRESS, REP_CNT=0.
- CE gating:
  - Stimulus: hold CE=0 for 50 CLK mid-DELAY with KEY_LEVEL toggling.
  - Required response: no pulses, state and timer frozen. The repeat schedule resumes from the frozen timer.
- Reset mid-REPEAT and saturation:
  - Stimulus: CLR during REPEAT.
  - Required response: next cycle all outputs 0, no KEY_REL.
  - Saturation sub-case: REP_W=2, 6 repeats → REP_CNT holds at 3.
